// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and index helpers for the 8-point FFT datapath
package fft_pkg;
  localparam int FFT_N     = 8;
  localparam int FFT_LOG2N = 3;
  localparam int FFT_DW    = 16;

  function automatic logic [FFT_LOG2N-1:0] bitrev3(input logic [FFT_LOG2N-1:0] i);
    return {i[0], i[1], i[2]};
  endfunction
endpackage

// File: rtl/p2s.sv
// p2s: captures an 8-word FFT frame in one cycle and streams it out one word per accepted beat
module p2s
  import fft_pkg::*;
#(
  parameter int DW = FFT_DW,
  parameter int N  = FFT_N
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          bitrev_en,
  input  logic [DW-1:0] p_in0,
  input  logic [DW-1:0] p_in1,
  input  logic [DW-1:0] p_in2,
  input  logic [DW-1:0] p_in3,
  input  logic [DW-1:0] p_in4,
  input  logic [DW-1:0] p_in5,
  input  logic [DW-1:0] p_in6,
  input  logic [DW-1:0] p_in7,
  output logic [DW-1:0] s_out,
  output logic          s_valid,
  input  logic          s_ready,
  output logic          s_last,
  output logic          busy,
  output logic          overflow
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]           state;
  logic [FFT_LOG2N-1:0] idx;
  logic                 rev;
  logic [DW-1:0]        data [N];
  logic [DW-1:0]        p_in [N];
  logic                 accept;
  logic                 last;
  logic                 capture;
  logic [FFT_LOG2N-1:0] rd_idx;

  assign p_in    = '{p_in0, p_in1, p_in2, p_in3, p_in4, p_in5, p_in6, p_in7};
  assign accept  = (state == SHIFT) && s_ready;
  assign last    = idx == FFT_LOG2N'(N - 1);
  assign capture = load && ((state == IDLE) || (accept && last));

  // serial output is a single mux over the held frame, gated to zero while idle
  always_comb begin
    rd_idx  = rev ? bitrev3(idx) : idx;
    s_valid = state == SHIFT;
    busy    = s_valid;
    s_last  = s_valid && last;
    s_out   = s_valid ? data[rd_idx] : '0;
  end

  // frame capture, beat counting and dropped-load pulse; a load that is not captured leaves the frame intact
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= '0;
      rev      <= 1'b0;
      data     <= '{default: '0};
      overflow <= 1'b0;
    end else begin
      if (capture) begin
        data <= p_in;
        rev  <= bitrev_en;
      end
      state    <= capture ? SHIFT : (accept && last) ? IDLE : state;
      idx      <= capture ? '0 : accept ? idx + FFT_LOG2N'(1) : idx;
      overflow <= load && !capture;
    end
  end
endmodule

// File: tb/tb_p2s.sv
// tb_p2s: scoreboard bench for p2s with directed scenarios and randomized traffic
module tb_p2s;
  typedef struct {
    logic [15:0] d;
    logic        l;
  } ent_t;

  localparam int REV_ORDER [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load;
  logic        bitrev_en;
  logic [15:0] p_in0, p_in1, p_in2, p_in3, p_in4, p_in5, p_in6, p_in7;
  logic [15:0] s_out;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic        busy;
  logic        overflow;

  ent_t        q    [$];
  ent_t        pend [$];
  logic [15:0] frm  [8];
  logic        ovf_next = 1'b0;
  logic        exp_ovf  = 1'b0;
  int          checks   = 0;
  int          errors   = 0;

  p2s dut (
    .clk(clk), .reset_n(reset_n), .load(load), .bitrev_en(bitrev_en),
    .p_in0(p_in0), .p_in1(p_in1), .p_in2(p_in2), .p_in3(p_in3),
    .p_in4(p_in4), .p_in5(p_in5), .p_in6(p_in6), .p_in7(p_in7),
    .s_out(s_out), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // monitor: compare what the DUT presents against the head of the scoreboard
  always @(negedge clk) begin
    logic ev;
    ev = q.size() > 0;
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("s_valid", 32'(s_valid), 32'(ev));
    chk("busy", 32'(busy), 32'(ev));
    chk("s_out", 32'(s_out), ev ? 32'(q[0].d) : 32'd0);
    chk("s_last", 32'(s_last), ev ? 32'(q[0].l) : 32'd0);
    if (ev && s_ready) void'(q.pop_front());
  end

  task automatic set_frame(input logic [15:0] base, input logic rnd);
    for (int k = 0; k < 8; k++) frm[k] = rnd ? 16'($urandom) : base + 16'(k);
  endtask

  // one clock of stimulus; the model decides whether this load will be taken
  task automatic cyc(input logic ld, input logic br, input logic rdy);
    logic acc;
    @(posedge clk);
    #1;
    while (pend.size() > 0) q.push_back(pend.pop_front());
    exp_ovf   = ovf_next;
    load      = ld;
    bitrev_en = br;
    s_ready   = rdy;
    p_in0 = ld ? frm[0] : 16'($urandom);
    p_in1 = ld ? frm[1] : 16'($urandom);
    p_in2 = ld ? frm[2] : 16'($urandom);
    p_in3 = ld ? frm[3] : 16'($urandom);
    p_in4 = ld ? frm[4] : 16'($urandom);
    p_in5 = ld ? frm[5] : 16'($urandom);
    p_in6 = ld ? frm[6] : 16'($urandom);
    p_in7 = ld ? frm[7] : 16'($urandom);
    acc = ld && (q.size() == 0 || (q.size() == 1 && rdy));
    if (acc)
      for (int k = 0; k < 8; k++) pend.push_back('{d: frm[br ? REV_ORDER[k] : k], l: k == 7});
    ovf_next = ld && !acc;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (q.size() > 0 || pend.size() > 0 || ovf_next); i++) cyc(1'b0, 1'($urandom), 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    checks++;
    if (q.size() > 0 || pend.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d words still expected after cycle budget, required 0", q.size() + pend.size());
      q.delete();
      pend.delete();
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    load      = 1'($urandom);
    bitrev_en = 1'($urandom);
    s_ready   = 1'($urandom);
    {p_in0, p_in1, p_in2, p_in3} = 64'({$urandom, $urandom});
    {p_in4, p_in5, p_in6, p_in7} = 64'({$urandom, $urandom});
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    load    = 1'b0;
    s_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);

    set_frame(16'h0010, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    drain();

    cyc(1'b1, 1'b1, 1'b1);
    drain();

    set_frame(16'h0100, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 24; i++) cyc(1'b0, 1'b0, (i % 3) == 2);
    drain();

    set_frame(16'h0A00, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    repeat (7) cyc(1'b0, 1'b0, 1'b1);
    set_frame(16'h0B00, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    set_frame(16'hDEAD, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    drain();

    set_frame(16'h0C00, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    reset_n  = 1'b0;
    q.delete();
    pend.delete();
    ovf_next = 1'b0;
    exp_ovf  = 1'b0;
    #1;
    chk("async_reset_valid", 32'(s_valid), 32'd0);
    chk("async_reset_out", 32'(s_out), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) cyc(1'b0, 1'($urandom), 1'b1);

    for (int i = 0; i < 400; i++) begin
      logic ld;
      ld = ($urandom_range(0, 5) == 0);
      if (ld) set_frame(16'h0, 1'b1);
      cyc(ld, 1'($urandom), $urandom_range(0, 3) != 0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/p2s.md
Name: p2s

Overview:
- Parallel-to-serial unloader for the 8-point FFT datapath, the output-side counterpart of the input serial-to-parallel buffer.
- Captures one 8-word FFT result frame in a single cycle and streams it out one 16-bit word per accepted beat, with a valid/ready handshake.
- Optional bit-reversed read order, so it can reorder a DIT/DIF frame into natural order.
- Sits between the butterfly output stage and the downstream serial sink.

Parameters:
- DW, 16, sample width in bits (real/imag packing is the caller's concern).
- N, 8, frame length in words; fixed at 8 for this revision, LOG2N = 3.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- load  input  1  one-cycle strobe; p_in0..p_in7 are valid this cycle.
- bitrev_en  input  1  sampled with load; 1 = emit in bit-reversed index order.
- p_in0..p_in7  input  DW each  parallel frame, word k on p_ink.
- s_out  output  DW  current serial word.
- s_valid  output  1  s_out is valid.
- s_ready  input  1  downstream accepts s_out this cycle.
- s_last  output  1  high with s_valid on the 8th word of a frame.
- busy  output  1  frame held and not yet fully drained (equals s_valid).
- overflow  output  1  one-cycle pulse: a load was dropped.

Behaviour:
- Storage: buf[0..7] of DW, idx[2:0] beat counter, rev flag, state register.
- Reset (async, reset_n low): buf = 0, idx = 0, rev = 0, state = IDLE. Outputs: s_out = 0, s_valid = 0, s_last = 0, busy = 0, overflow = 0.
- Reset mid-frame: the frame is discarded, with no partial output after release.
- Accept = s_valid && s_ready.
- States and transitions:
  - IDLE, load = 1: capture p_in0..7 into buf[0..7], rev = bitrev_en, idx = 0, go to SHIFT.
  - IDLE, load = 0: stay.
  - SHIFT, no accept: hold s_out, idx and s_last stable. Words are never dropped or repeated.
  - SHIFT, accept with idx < 7: idx = idx + 1.
  - SHIFT, accept with idx = 7 and load = 1: back-to-back. Capture the new frame, idx = 0, stay in SHIFT, no bubble.
  - SHIFT, accept with idx = 7 and load = 0: idx = 0, go to IDLE.
- Output mapping:
  - s_out = buf[rev ? bitrev3(idx) : idx] in SHIFT, 0 in IDLE.
  - bitrev3 maps {b2,b1,b0} to {b0,b1,b2}, giving order 0,4,2,6,1,5,3,7.
  - s_valid = busy = (state == SHIFT).
  - s_last = s_valid && (idx == 7).
- Latency: load at edge k puts word 0 on s_out with s_valid = 1 after edge k, i.e. visible in cycle k+1. With s_ready held at 1, a frame drains in 8 cycles. Sustained throughput is 1 frame per 8 cycles.
- Overflow: load in SHIFT without a final accept in the same cycle is ignored; buf and rev are unchanged. overflow = 1 for exactly the next cycle. A load accepted in the back-to-back case does not set overflow.
- bitrev_en is ignored when no capture occurs.
- No arithmetic on data; words pass through bit-exact.
- idx is a 3-bit counter that wraps only through the idx = 7 transitions above.
- Combinational output path is a single 8:1 mux from registers; no input-to-output combinational path other than s_ready into the next-state logic.

Decomposition:
- Shared package fft_pkg holds:
  - constants FFT_N = 8, FFT_LOG2N = 3, FFT_DW = 16;
  - function bitrev3, also to be reused by the twiddle/reorder logic.
- No sub-module. State is a 1-bit encoding (IDLE = 0, SHIFT = 1) defined locally.

Test Plan:
- Reset check: reset_n = 0 for 3 cycles with random inputs -> s_out = 0, s_valid = 0, s_last = 0, busy = 0, overflow = 0 throughout.
- Natural order: load p_in = 0x0010..0x0017, bitrev_en = 0, s_ready = 1 -> s_out = 0x0010..0x0017 on 8 consecutive cycles starting the cycle after load. s_last = 1 only with 0x0017, then s_valid = 0.
- Bit-reversed order: same frame with bitrev_en = 1 -> sequence 0x0010, 0x0014, 0x0012, 0x0016, 0x0011, 0x0015, 0x0013, 0x0017.
- Backpressure: s_ready toggles 1,0,0,1,… -> s_out/s_last stable while s_ready = 0. All 8 words arrive exactly once, in order.
- Back-to-back and overflow:
  - Frame B loaded on the cycle of frame A's last accept -> B word 0 follows A word 7 with no gap; overflow stays 0.
  - A load at idx = 3 -> dropped, overflow = 1 for one cycle, frame A output unchanged.
- Mid-frame reset: assert reset_n = 0 at idx = 4 -> s_valid = 0 immediately (asynchronous). After release, IDLE with no residual words until the next load.
